// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 core, one block at a time, encrypt or decrypt per block.
// Each round takes two cycles (SUB registers the S-box output, LIN applies the linear layer and the
// round key). Round keys are expanded combinationally from the key latched at accept.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_valid, o_ready  input handshake (o_ready high only when idle)
//   i_mode            0 = encrypt, 1 = decrypt; latched at accept
//   i_block, i_key    input block / cipher key, byte 0 in the most significant bits
//   o_valid, i_ready  output handshake
//   o_block           result; holds the last result after the output handshake
//   o_busy            high whenever not idle
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_mode,
    input  logic [127:0]        i_block,
    input  logic [KEY_BITS-1:0] i_key,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [127:0]        o_block,
    output logic                o_busy
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int CW = $clog2(NR + 1);
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    // ---------------------------------------------------------------- GF(2^8) helpers
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
    endfunction

    // ---------------------------------------------------------------- round transforms
    // State byte n sits at bits [127-8n -: 8]; row = n % 4, column = n / 4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127-8*n -: 8] = inv ? sbox_inv(s[127-8*n -: 8]) : sbox_fwd(s[127-8*n -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src = inv ? row + 4 * ((c - row + 4) % 4) : row + 4 * ((c + row) % 4);
                r[127-8*(row+4*c) -: 8] = s[127-8*src -: 8];
            end
        end
        return r;
    endfunction

    // Both matrices are circulant: row r uses coefficient (j - r) mod 4 for input byte j.
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [31:0]  cf;
        logic [7:0]   acc;
        r  = '0;
        cf = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(cf[31-8*((j-row+4)%4) -: 8], s[127-8*(j+4*c) -: 8]);
                end
                r[127-8*(row+4*c) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    typedef enum logic [2:0] {StIdle, StInit, StSub, StLin, StDone} st_e;

    st_e                 st_q, st_d;
    logic [127:0]        blk_q, blk_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                mode_q, mode_d;
    logic [127:0]        state_q, state_d;
    logic [127:0]        sb_q, sb_d;
    logic [CW-1:0]       ctr_q, ctr_d;
    logic                valid_q, valid_d;
    logic [127:0]        out_q, out_d;

    // ---------------------------------------------------------------- key expansion
    logic [31:0]  w      [NW];
    logic [127:0] rkeys  [NR+1];
    logic [127:0] rk_cur;

    always_comb begin
        logic [31:0] tmp;
        logic [7:0]  rc;
        tmp = '0;
        rc  = 8'h01;
        for (int i = 0; i < NW; i++) begin
            if (i < NK) begin
                w[i] = key_q[KEY_BITS-1-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % NK == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = xtime(rc);
                end else if (NK > 6 && i % NK == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-NK] ^ tmp;
            end
        end
    end

    always_comb begin
        for (int r = 0; r <= NR; r++) begin
            rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

    assign rk_cur = rkeys[ctr_q];

    // ---------------------------------------------------------------- datapath + FSM
    logic [127:0] enc_sr;
    logic [127:0] dec_t;

    assign enc_sr = shift_rows(sb_q, 1'b0);
    // Inverse ShiftRows applied after InvSubBytes; the two commute, so the S-box stage is shared.
    assign dec_t  = shift_rows(sb_q, 1'b1) ^ rk_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= StIdle;
            blk_q   <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            state_q <= '0;
            sb_q    <= '0;
            ctr_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            st_q    <= st_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            sb_q    <= sb_d;
            ctr_q   <= ctr_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        blk_d   = blk_q;
        key_d   = key_q;
        mode_d  = mode_q;
        state_d = state_q;
        sb_d    = sb_q;
        ctr_d   = ctr_q;
        valid_d = valid_q;
        out_d   = out_q;

        unique case (st_q)
            StIdle: begin
                if (i_valid) begin
                    blk_d  = i_block;
                    key_d  = i_key;
                    mode_d = i_mode;
                    st_d   = StInit;
                end
            end
            StInit: begin
                state_d = blk_q ^ (mode_q ? rkeys[NR] : rkeys[0]);
                ctr_d   = mode_q ? CW'(NR - 1) : CW'(1);
                st_d    = StSub;
            end
            StSub: begin
                sb_d = sub_bytes(state_q, mode_q);
                st_d = StLin;
            end
            StLin: begin
                if (!mode_q) begin
                    if (ctr_q == CW'(NR)) begin
                        state_d = enc_sr ^ rk_cur;
                        st_d    = StDone;
                    end else begin
                        state_d = mix_columns(enc_sr, 1'b0) ^ rk_cur;
                        ctr_d   = ctr_q + CW'(1);
                        st_d    = StSub;
                    end
                end else begin
                    if (ctr_q == '0) begin
                        state_d = dec_t;
                        st_d    = StDone;
                    end else begin
                        state_d = mix_columns(dec_t, 1'b1);
                        ctr_d   = ctr_q - CW'(1);
                        st_d    = StSub;
                    end
                end
            end
            StDone: begin
                // First DONE cycle copies the result into the output register; o_valid rises
                // with it, so neither output depends combinationally on i_ready.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    out_d   = state_q;
                end else if (i_ready) begin
                    valid_d = 1'b0;
                    st_d    = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    assign o_ready = (st_q == StIdle);
    assign o_busy  = (st_q != StIdle);
    assign o_valid = valid_q;
    assign o_block = out_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: one instance each of AES-128/192/256 sharing clock and
// reset. Expected blocks and accept cycles are queued at accept and checked when the DUT
// presents its result.
module tb_aes_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   iv, md, ir, ordy, ov, busy;
    logic [127:0] blk [3];
    logic [255:0] key [3];
    logic [127:0] ob  [3];

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst), .i_valid(iv[0]), .o_ready(ordy[0]), .i_mode(md[0]),
        .i_block(blk[0]), .i_key(key[0][127:0]), .o_valid(ov[0]), .i_ready(ir[0]),
        .o_block(ob[0]), .o_busy(busy[0])
    );
    aes_iter_core #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst), .i_valid(iv[1]), .o_ready(ordy[1]), .i_mode(md[1]),
        .i_block(blk[1]), .i_key(key[1][191:0]), .o_valid(ov[1]), .i_ready(ir[1]),
        .o_block(ob[1]), .o_busy(busy[1])
    );
    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .i_valid(iv[2]), .o_ready(ordy[2]), .i_mode(md[2]),
        .i_block(blk[2]), .i_key(key[2][255:0]), .o_valid(ov[2]), .i_ready(ir[2]),
        .o_block(ob[2]), .o_busy(busy[2])
    );

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic [255:0] kvec [3];
    logic [127:0] ctv  [3];

    typedef struct {
        int           dut;
        logic [127:0] exp;
        int           acc;
    } sb_t;

    sb_t sbq[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return 22 + 4 * k;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int find_entry(input int k);
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].dut == k) return i;
        end
        return -1;
    endfunction

    // Output monitor: latency on the rising edge of o_valid, data on each output handshake.
    logic [2:0] ov_prev = '0;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = find_entry(k);
            if (ov[k] && !ov_prev[k]) begin
                if (idx < 0) check_eq($sformatf("spurious_valid%0d", k), {127'b0, ov[k]}, '0);
                else check_eq($sformatf("latency%0d", k), cyc - sbq[idx].acc, lat(k));
            end
            if (ov[k] && ir[k] && idx >= 0) begin
                check_eq($sformatf("block%0d", k), ob[k], sbq[idx].exp);
                sbq.delete(idx);
            end
            ov_prev[k] = ov[k];
        end
    end

    // Called at posedge+1. While the core is busy, junk is driven on mode/block/key; real values
    // are set only on the negedge that sees o_ready, and scrambled again after accept.
    task automatic send(input int k, input logic mode, input logic [127:0] b,
                        input logic [255:0] kk, input logic [127:0] exp, output int acc);
        bit got;
        got   = 1'b0;
        acc   = -1;
        iv[k] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (ordy[k]) begin
                md[k]  = mode;
                blk[k] = b;
                key[k] = kk;
                got    = 1'b1;
            end else begin
                md[k]  = 1'($urandom);
                blk[k] = {$urandom, $urandom, $urandom, $urandom};
                key[k] = {8{$urandom}};
            end
        end
        if (!got) begin
            check_eq("accept_timeout", {127'b0, ordy[k]}, 128'd1);
            iv[k] = 1'b0;
        end else begin
            acc = cyc + 1;
            sbq.push_back('{k, exp, acc});
            @(posedge clk);
            #1;
            iv[k]  = 1'b0;
            md[k]  = ~mode;
            blk[k] = {$urandom, $urandom, $urandom, $urandom};
            key[k] = {8{$urandom}};
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 500; n++) begin
            if (sbq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_eq("drain", sbq.size(), '0);
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc;
        int prev;
        int idx;

        kvec[0] = 256'h000102030405060708090a0b0c0d0e0f;
        kvec[1] = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
        kvec[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ctv[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ctv[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ctv[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst = 1'b1;
        iv  = '0;
        ir  = '0;
        md  = '0;
        for (int k = 0; k < 3; k++) begin
            blk[k] = '0;
            key[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_ready%0d", k), {127'b0, ordy[k]}, 128'd1);
            check_eq($sformatf("rst_valid%0d", k), {127'b0, ov[k]}, 128'd0);
            check_eq($sformatf("rst_busy%0d", k), {127'b0, busy[k]}, 128'd0);
            check_eq($sformatf("rst_block%0d", k), ob[k], 128'd0);
        end

        // FIPS-197 vectors, encrypt then decrypt, for each key length.
        for (int k = 0; k < 3; k++) begin
            ir[k] = 1'b1;
            send(k, 1'b0, PT, kvec[k], ctv[k], acc);
            wait_drain();
            send(k, 1'b1, ctv[k], kvec[k], PT, acc);
            wait_drain();
        end

        // Back-to-back, alternating mode; accepts must be exactly 2*NR+4 cycles apart.
        for (int k = 0; k < 3; k++) begin
            prev = 0;
            for (int j = 0; j < 4; j++) begin
                if (j[0]) send(k, 1'b1, ctv[k], kvec[k], PT, acc);
                else      send(k, 1'b0, PT, kvec[k], ctv[k], acc);
                if (j > 0) check_eq($sformatf("period%0d", k), acc - prev, 24 + 4 * k);
                prev = acc;
            end
            wait_drain();
        end

        // Backpressure on AES-256, with an ignored i_valid pulse carrying a different key.
        ir[2] = 1'b0;
        send(2, 1'b0, PT, kvec[2], ctv[2], acc);
        for (int n = 0; n < 100 && !ov[2]; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("bp_wait", {127'b0, ov[2]}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", {127'b0, ov[2]}, 128'd1);
            check_eq("bp_block", ob[2], ctv[2]);
            check_eq("bp_ready", {127'b0, ordy[2]}, 128'd0);
            if (i == 3) begin
                key[2] = ~kvec[2];
                md[2]  = 1'b1;
                blk[2] = ~PT;
                iv[2]  = 1'b1;
            end
            if (i == 6) iv[2] = 1'b0;
        end
        ir[2] = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;
        check_eq("post_hs_valid", {127'b0, ov[2]}, 128'd0);
        check_eq("post_hs_block", ob[2], ctv[2]);
        check_eq("post_hs_ready", {127'b0, ordy[2]}, 128'd1);

        // Reset during round 5 of an AES-128 block, then a fresh block.
        send(0, 1'b0, PT, kvec[0], ctv[0], acc);
        for (int n = 0; n < 100 && cyc < acc + 10; n++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", {127'b0, ov[0]}, 128'd0);
        check_eq("midrst_block", ob[0], 128'd0);
        check_eq("midrst_busy", {127'b0, busy[0]}, 128'd0);
        check_eq("midrst_ready", {127'b0, ordy[0]}, 128'd1);
        idx = find_entry(0);
        if (idx >= 0) sbq.delete(idx);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 1'b0, PT, kvec[0], ctv[0], acc);
        wait_drain();
        send(0, 1'b1, ctv[0], kvec[0], PT, acc);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
